// File: rtl/tusca_tx_arbiter_pkg.sv
// Shared constants for the TUSCA transmit path: arbiter FSM state codes,
// requester indices and the round-robin successor helper.
package tusca_pkg;

    localparam logic [3:0] ST_IDLE        = 4'd0;
    localparam logic [3:0] ST_ARBITRA     = 4'd1;
    localparam logic [3:0] ST_ESPERA_DADO = 4'd2;
    localparam logic [3:0] ST_ENVIA       = 4'd3;
    localparam logic [3:0] ST_AGUARDA_TX  = 4'd4;
    localparam logic [3:0] ST_LIBERA      = 4'd5;
    localparam logic [3:0] ST_TIMEOUT     = 4'd6;

    localparam logic [1:0] REQ_MEDIDA = 2'd0;
    localparam logic [1:0] REQ_CONFIG = 2'd1;
    localparam logic [1:0] REQ_ERRO   = 2'd2;

    localparam int unsigned N_REQ = 3;

    // Next requester index in round-robin order, wrapping after REQ_ERRO.
    function automatic logic [1:0] idx_seguinte(input logic [1:0] idx);
        return (idx >= REQ_ERRO) ? REQ_MEDIDA : idx + 2'd1;
    endfunction

endpackage

// File: rtl/tusca_tx_arbiter_contador_m.sv
// Modulo-M counter with synchronous clear; fim flags the terminal count M-1.
module contador_m #(
    parameter int M = 100,
    parameter int N = 7
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [N-1:0] q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (zera)
            q <= '0;
        else if (conta)
            q <= (q == N'(M - 1)) ? '0 : q + N'(1);
    end

    assign fim = (q == N'(M - 1));

endmodule

// File: rtl/tusca_tx_arbiter_rr_picker.sv
// Combinational round-robin selector: first active request after ptr,
// returned both one-hot and as an index.
module rr_picker
    import tusca_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] sel,
    output logic [1:0] idx
);

    logic [1:0] cand;

    always_comb begin
        sel  = '0;
        idx  = REQ_MEDIDA;
        cand = idx_seguinte(ptr);
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (sel == '0 && req[cand]) begin
                sel[cand] = 1'b1;
                idx       = cand;
            end
            cand = idx_seguinte(cand);
        end
    end

endmodule

// File: rtl/tusca_tx_arbiter.sv
// Round-robin owner of the shared UART transmitter for the measurement,
// config-ack and error requesters; one whole message per grant, with watchdog.
module tusca_tx_arbiter
    import tusca_pkg::*;
#(
    parameter int TIMEOUT = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] dados,
    input  logic [2:0]  valido,
    input  logic [2:0]  ultimo,
    output logic [2:0]  aceito,
    output logic [2:0]  grant,
    output logic        tx_partida,
    output logic [7:0]  tx_dados,
    input  logic        tx_pronto,
    output logic        timeout_erro,
    output logic [3:0]  db_estado
);

    logic [3:0] estado, estado_prox;
    logic [1:0] ptr, g_idx;
    logic [2:0] pick_sel;
    logic [1:0] pick_idx;
    logic       fim;
    logic [7:0] byte_g;
    logic       req_g, valido_g, ultimo_g;
    logic       wd_zera, wd_conta, wd_fim;

    rr_picker u_picker (
        .req (req),
        .ptr (ptr),
        .sel (pick_sel),
        .idx (pick_idx)
    );

    // Only the granted requester's lines are visible to the FSM.
    always_comb begin
        case (g_idx)
            REQ_CONFIG: begin
                byte_g   = dados[15:8];
                req_g    = req[1];
                valido_g = valido[1];
                ultimo_g = ultimo[1];
            end
            REQ_ERRO: begin
                byte_g   = dados[23:16];
                req_g    = req[2];
                valido_g = valido[2];
                ultimo_g = ultimo[2];
            end
            default: begin
                byte_g   = dados[7:0];
                req_g    = req[0];
                valido_g = valido[0];
                ultimo_g = ultimo[0];
            end
        endcase
    end

    always_comb begin
        estado_prox = estado;
        case (estado)
            ST_IDLE:
                if (|req) estado_prox = ST_ARBITRA;
            ST_ARBITRA:
                estado_prox = (|req) ? ST_ESPERA_DADO : ST_IDLE;
            ST_ESPERA_DADO:
                if (valido_g)    estado_prox = ST_ENVIA;
                else if (!req_g) estado_prox = ST_LIBERA;
                else if (wd_fim) estado_prox = ST_TIMEOUT;
            ST_ENVIA:
                estado_prox = ST_AGUARDA_TX;
            ST_AGUARDA_TX:
                if (tx_pronto)   estado_prox = fim ? ST_LIBERA : ST_ESPERA_DADO;
                else if (wd_fim) estado_prox = ST_TIMEOUT;
            ST_LIBERA:
                estado_prox = ST_IDLE;
            ST_TIMEOUT:
                estado_prox = ST_LIBERA;
            default:
                estado_prox = ST_IDLE;
        endcase
    end

    // Clearing on every state change restarts the count on each entry into
    // ESPERA_DADO or AGUARDA_TX, including the direct hop between them.
    assign wd_conta = (estado == ST_ESPERA_DADO) || (estado == ST_AGUARDA_TX);
    assign wd_zera  = (estado_prox != estado);

    contador_m #(
        .M (TIMEOUT),
        .N (27)
    ) u_watchdog (
        .clock (clock),
        .reset (reset),
        .zera  (wd_zera),
        .conta (wd_conta),
        .fim   (wd_fim)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado   <= ST_IDLE;
            ptr      <= REQ_ERRO;
            g_idx    <= REQ_MEDIDA;
            grant    <= '0;
            tx_dados <= '0;
            fim      <= 1'b0;
        end else begin
            estado <= estado_prox;
            case (estado)
                ST_ARBITRA:
                    if (|req) begin
                        grant <= pick_sel;
                        g_idx <= pick_idx;
                    end
                ST_ESPERA_DADO:
                    if (valido_g) begin
                        tx_dados <= byte_g;
                        fim      <= ultimo_g;
                    end
                ST_LIBERA: begin
                    ptr   <= g_idx;
                    grant <= '0;
                end
                default: ;
            endcase
        end
    end

    assign aceito       = (estado == ST_ENVIA) ? grant : '0;
    assign tx_partida   = (estado == ST_ENVIA);
    assign timeout_erro = (estado == ST_TIMEOUT);
    assign db_estado    = estado;

endmodule

// File: tb/tb_tusca_tx_arbiter.sv
// Scoreboard bench for tusca_tx_arbiter: requester and UART models drive the
// DUT, expected grant/byte/timeout events are queued and checked by a monitor.
module tb_tusca_tx_arbiter;

    localparam int TMO = 20;
    localparam logic [1:0] EV_GRANT = 2'd0;
    localparam logic [1:0] EV_BYTE  = 2'd1;
    localparam logic [1:0] EV_TMO   = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [2:0] g;
        logic [7:0] d;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req, valido, ultimo, aceito, grant;
    logic [23:0] dados;
    logic        tx_partida, tx_pronto, timeout_erro;
    logic [7:0]  tx_dados;
    logic [3:0]  db_estado;

    logic       r_req[3], r_valido[3], r_ultimo[3], busy[3], stall_v[3];
    logic [7:0] r_dados[3];
    logic [7:0] msg[3][4];
    int         len[3], abort_at[3], req_rise_cyc[3], grant_cyc[3];
    logic       uart_stall;

    ev_t        exp_q[$];
    int         checks = 0, errors = 0;
    int         cyc = 0, entry_cyc = 0, n_partida = 0;
    logic [2:0] grant_prev;
    logic [3:0] est_prev;

    assign req    = {r_req[2], r_req[1], r_req[0]};
    assign valido = {r_valido[2], r_valido[1], r_valido[0]};
    assign ultimo = {r_ultimo[2], r_ultimo[1], r_ultimo[0]};
    assign dados  = {r_dados[2], r_dados[1], r_dados[0]};

    tusca_tx_arbiter #(.TIMEOUT(TMO)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .dados        (dados),
        .valido       (valido),
        .ultimo       (ultimo),
        .aceito       (aceito),
        .grant        (grant),
        .tx_partida   (tx_partida),
        .tx_dados     (tx_dados),
        .tx_pronto    (tx_pronto),
        .timeout_erro (timeout_erro),
        .db_estado    (db_estado)
    );

    initial forever #5 clock = ~clock;
    initial forever begin
        @(posedge clock);
        cyc++;
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp_v);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [2:0] g, input logic [7:0] d);
        ev_t e;
        e.kind = kind;
        e.g    = g;
        e.d    = d;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input logic [1:0] kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind %0d grant %b tx_dados 0x%h, nothing expected",
                     kind, grant, tx_dados);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.g !== grant ||
            (kind == EV_BYTE && (e.d !== tx_dados || aceito !== e.g))) begin
            errors++;
            $display("FAIL event: got kind %0d grant %b aceito %b tx_dados 0x%h, expected kind %0d grant %b tx_dados 0x%h",
                     kind, grant, aceito, tx_dados, e.kind, e.g, e.d);
        end
    endtask

    // Monitor: every grant rise, tx_partida or timeout_erro consumes one expectation.
    initial begin
        grant_prev = '0;
        est_prev   = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                grant_prev = '0;
                est_prev   = '0;
            end else begin
                if (db_estado != est_prev && (db_estado == 4'd2 || db_estado == 4'd4))
                    entry_cyc = cyc;
                if (grant_prev == '0 && grant != '0) begin
                    for (int i = 0; i < 3; i++)
                        if (grant[i]) grant_cyc[i] = cyc;
                    expect_ev(EV_GRANT);
                end
                if (tx_partida) begin
                    n_partida++;
                    expect_ev(EV_BYTE);
                end
                if (timeout_erro) begin
                    expect_ev(EV_TMO);
                    check8("timeout_delay", 8'(cyc - entry_cyc), 8'(TMO));
                end
                if (aceito != '0 && !tx_partida) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_aceito: got %b, expected 000", aceito);
                end
                grant_prev = grant;
                est_prev   = db_estado;
            end
        end
    end

    // UART model: done pulse 10 cycles after each start unless stalled.
    initial begin
        tx_pronto = 1'b0;
        forever begin
            @(negedge clock);
            if (tx_partida && !uart_stall) begin
                repeat (10) @(negedge clock);
                tx_pronto = 1'b1;
                @(negedge clock);
                tx_pronto = 1'b0;
            end
        end
    end

    task automatic requester(input int i);
        int n;
        forever begin
            @(negedge clock);
            if (busy[i]) begin
                r_req[i]        = 1'b1;
                req_rise_cyc[i] = cyc;
                n = 0;
                if (stall_v[i]) begin
                    while (!grant[i] && n < 400) begin @(negedge clock); n++; end
                    while (grant[i] && n < 400)  begin @(negedge clock); n++; end
                    if (n >= 400) begin
                        checks++;
                        errors++;
                        $display("FAIL stall_release: requester %0d grant %b, expected release", i, grant);
                    end
                end else begin
                    for (int b = 0; b < len[i]; b++) begin
                        r_dados[i]  = msg[i][b];
                        r_ultimo[i] = (b == len[i] - 1);
                        r_valido[i] = 1'b1;
                        n = 0;
                        do begin @(negedge clock); n++; end
                        while (!aceito[i] && n < 400);
                        r_valido[i] = 1'b0;
                        r_ultimo[i] = 1'b0;
                        if (!aceito[i]) begin
                            checks++;
                            errors++;
                            $display("FAIL aceito_wait: requester %0d byte %0d got no aceito, expected one", i, b);
                            break;
                        end
                        if (abort_at[i] != 0 && b + 1 == abort_at[i]) break;
                    end
                end
                r_req[i] = 1'b0;
                busy[i]  = 1'b0;
            end
        end
    endtask

    initial requester(0);
    initial requester(1);
    initial requester(2);

    task automatic setup(input int i, input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int ab, input logic st);
        msg[i][0]   = b0;
        msg[i][1]   = b1;
        msg[i][2]   = b2;
        msg[i][3]   = 8'h00;
        len[i]      = n;
        abort_at[i] = ab;
        stall_v[i]  = st;
    endtask

    task automatic launch(input logic [2:0] mask);
        @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++)
            if (mask[i]) busy[i] = 1'b1;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        do begin @(negedge clock); n++; end
        while ((busy[0] || busy[1] || busy[2] || db_estado != 4'd0 || exp_q.size() != 0) && n < 3000);
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL %s: state %0d with %0d events pending, expected idle and none", name,
                     db_estado, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check8({tag, "_grant"},        8'(grant),        8'h00);
        check8({tag, "_aceito"},       8'(aceito),       8'h00);
        check8({tag, "_tx_partida"},   8'(tx_partida),   8'h00);
        check8({tag, "_tx_dados"},     tx_dados,         8'h00);
        check8({tag, "_timeout_erro"}, 8'(timeout_erro), 8'h00);
        check8({tag, "_db_estado"},    8'(db_estado),    8'h00);
    endtask

    initial begin
        int n, np0, rel;
        for (int i = 0; i < 3; i++) begin
            r_req[i]    = 1'b0;
            r_valido[i] = 1'b0;
            r_ultimo[i] = 1'b0;
            r_dados[i]  = 8'h00;
            busy[i]     = 1'b0;
            stall_v[i]  = 1'b0;
            len[i]      = 0;
            abort_at[i] = 0;
        end
        uart_stall = 1'b0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b1;

        // Contention from reset: 0, 1, 2.
        setup(0, 1, 8'hA1, 8'h00, 8'h00, 0, 1'b0);
        setup(1, 1, 8'hB1, 8'h00, 8'h00, 0, 1'b0);
        setup(2, 1, 8'hC1, 8'h00, 8'h00, 0, 1'b0);
        push(EV_GRANT, 3'b001, 8'h00); push(EV_BYTE, 3'b001, 8'hA1);
        push(EV_GRANT, 3'b010, 8'h00); push(EV_BYTE, 3'b010, 8'hB1);
        push(EV_GRANT, 3'b100, 8'h00); push(EV_BYTE, 3'b100, 8'hC1);
        launch(3'b111);
        wait_done("contention_3");

        // ptr back at 2: req0 (two bytes, not interleaved) then req2.
        setup(0, 2, 8'hA2, 8'hA3, 8'h00, 0, 1'b0);
        setup(2, 1, 8'hC2, 8'h00, 8'h00, 0, 1'b0);
        push(EV_GRANT, 3'b001, 8'h00); push(EV_BYTE, 3'b001, 8'hA2);
        push(EV_BYTE, 3'b001, 8'hA3);
        push(EV_GRANT, 3'b100, 8'h00); push(EV_BYTE, 3'b100, 8'hC2);
        launch(3'b101);
        wait_done("contention_02");

        // Single message 0x54, 0x32.
        setup(0, 2, 8'h54, 8'h32, 8'h00, 0, 1'b0);
        push(EV_GRANT, 3'b001, 8'h00); push(EV_BYTE, 3'b001, 8'h54);
        push(EV_BYTE, 3'b001, 8'h32);
        launch(3'b001);
        wait_done("single");
        check8("grant_latency", 8'(grant_cyc[0] - req_rise_cyc[0]), 8'd2);
        repeat (5) @(negedge clock);
        check8("single_grant_end", 8'(grant), 8'h00);
        check8("single_state_end", 8'(db_estado), 8'h00);

        // Stalled requester 1 (ptr=0), requester 2 served afterwards.
        setup(1, 1, 8'h00, 8'h00, 8'h00, 0, 1'b1);
        setup(2, 1, 8'hC3, 8'h00, 8'h00, 0, 1'b0);
        push(EV_GRANT, 3'b010, 8'h00); push(EV_TMO, 3'b010, 8'h00);
        push(EV_GRANT, 3'b100, 8'h00); push(EV_BYTE, 3'b100, 8'hC3);
        launch(3'b110);
        wait_done("stall_req");

        // Stalled UART, then a normal message.
        uart_stall = 1'b1;
        setup(0, 1, 8'hD1, 8'h00, 8'h00, 0, 1'b0);
        push(EV_GRANT, 3'b001, 8'h00); push(EV_BYTE, 3'b001, 8'hD1);
        push(EV_TMO, 3'b001, 8'h00);
        launch(3'b001);
        wait_done("stall_uart");
        uart_stall = 1'b0;
        setup(2, 1, 8'hC4, 8'h00, 8'h00, 0, 1'b0);
        push(EV_GRANT, 3'b100, 8'h00); push(EV_BYTE, 3'b100, 8'hC4);
        launch(3'b100);
        wait_done("after_stall_uart");

        // Abort after the first of three bytes; stray valido from others.
        np0 = n_partida;
        setup(0, 3, 8'hE1, 8'hE2, 8'hE3, 1, 1'b0);
        push(EV_GRANT, 3'b001, 8'h00); push(EV_BYTE, 3'b001, 8'hE1);
        launch(3'b001);
        repeat (4) @(negedge clock);
        r_dados[1] = 8'hFF; r_valido[1] = 1'b1;
        r_dados[2] = 8'hEE; r_valido[2] = 1'b1;
        repeat (3) @(negedge clock);
        r_valido[1] = 1'b0; r_valido[2] = 1'b0;
        wait_done("abort");
        check8("abort_partida_count", 8'(n_partida - np0), 8'd1);

        // Reset during AGUARDA_TX, then req0+req1 with ptr back at 2.
        uart_stall = 1'b1;
        push(EV_GRANT, 3'b001, 8'h00); push(EV_BYTE, 3'b001, 8'hA5);
        @(posedge clock); #1;
        r_req[0] = 1'b1; r_dados[0] = 8'hA5; r_ultimo[0] = 1'b0; r_valido[0] = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (!tx_partida && n < 100);
        r_valido[0] = 1'b0;
        @(negedge clock);
        check8("state_before_reset", 8'(db_estado), 8'd4);
        #2 reset = 1'b0;
        #1 check_reset_outputs("midreset");
        repeat (2) @(negedge clock);
        r_req[1] = 1'b1;
        push(EV_GRANT, 3'b001, 8'h00);
        rel   = cyc;
        reset = 1'b1;
        n = 0;
        do begin @(negedge clock); n++; end while (grant == '0 && n < 20);
        check8("reset_regrant", 8'(grant), 8'h01);
        check8("reset_regrant_latency", 8'(cyc - rel), 8'd2);
        r_req[0] = 1'b0;
        r_req[1] = 1'b0;
        uart_stall = 1'b0;
        wait_done("reset_recover");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tusca_tx_arbiter.md
# tusca_tx_arbiter

Shares the single serial transmitter on `tx_serial` between three byte-stream requesters: measurement report, configuration acknowledge, and error report. It sits between those requesters and the UART transmitter. It grants the transmitter round-robin, one whole message at a time, and forwards each byte with a start/done handshake. A watchdog releases the grant if a requester or the transmitter stalls.

## Interface
- `TIMEOUT`, 50_000_000: stall limit in cycles, 1 s at 50 MHz.
- `clock`  in  1  system clock; every register is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-low.
- `req`  in  3  message request, held until the last byte is accepted. Bit 0 = medida, 1 = config ack, 2 = erro.
- `dados`  in  24  byte per requester; requester i drives `dados[8i+7:8i]`.
- `valido`  in  3  byte valid; requester holds `valido` and its byte until `aceito`.
- `ultimo`  in  3  marks the current byte as the last one of the message.
- `aceito`  out  3  one-cycle pulse to the granted requester: byte consumed.
- `grant`  out  3  one-hot current owner; all zero when idle.
- `tx_partida`  out  1  one-cycle start pulse to the UART transmitter.
- `tx_dados`  out  8  byte to transmit; stable from `tx_partida` until `tx_pronto`.
- `tx_pronto`  in  1  UART done pulse.
- `timeout_erro`  out  1  one-cycle pulse when the watchdog fires.
- `db_estado`  out  4  current FSM state code, for `hexa7seg`.

## Operation
- FSM states and codes:
  - IDLE (0): if any `req` bit is high → ARBITRA.
  - ARBITRA (1): round-robin pick.
    - Search starts at index (`ptr`+1) mod 3; `ptr` is the last granted index and resets to 2, so requester 0 wins first.
    - Register `grant`, → ESPERA_DADO.
    - If `req` is all zero by now → IDLE.
  - ESPERA_DADO (2):
    - `valido[g]` → latch `dados[g]` into `tx_dados` and `ultimo[g]` into `fim`, → ENVIA.
    - Else `req[g]` low → LIBERA (requester abandoned the message).
    - Else timer = `TIMEOUT`-1 → TIMEOUT.
  - ENVIA (3): `aceito[g]`=1 and `tx_partida`=1 for this cycle only, → AGUARDA_TX.
  - AGUARDA_TX (4): `tx_pronto` → LIBERA if `fim`, else → ESPERA_DADO. Timer = `TIMEOUT`-1 → TIMEOUT.
  - LIBERA (5): `ptr` ← g, `grant` ← 0, → IDLE.
  - TIMEOUT (6): `timeout_erro`=1 for one cycle, → LIBERA.
- Watchdog: 27-bit counter, cleared on entry to ESPERA_DADO and AGUARDA_TX, increments only in those two states.
- `valido`/`ultimo` from non-granted requesters are ignored.
- A `req` that drops while in AGUARDA_TX does not abort the byte in flight. It is detected at the next ESPERA_DADO.
- `tx_pronto` outside AGUARDA_TX is ignored.
- Reset mid-operation: FSM → IDLE and all outputs return to their reset values. No byte is replayed after reset.
- Reset values: `grant`=0, `aceito`=0, `tx_partida`=0, `tx_dados`=0x00, `timeout_erro`=0, `db_estado`=0, `ptr`=2.

## Timing
- Handshake (`req`/`valido`/`ultimo` → `grant`/`aceito`/`tx_partida`):
  - `req` rising in IDLE at cycle t → `grant` valid at t+2.
  - `valido` sampled at cycle c in ESPERA_DADO → `aceito` and `tx_partida` at c+1.
- Transmitter hand-off (`tx_pronto`):
  - `tx_pronto` at cycle d with `fim`=0 → back in ESPERA_DADO at d+1. The next byte can start at d+2 at the earliest.
  - `tx_pronto` with `fim`=1 at cycle d → `grant`=0 at d+2. A competing requester is granted at d+4.
- Overhead: 3 cycles per byte plus UART time; 5 cycles of arbitration between messages.
- Simultaneous events:
  - `tx_pronto` and timeout in the same cycle: `tx_pronto` wins.
  - `valido` and timeout in the same cycle: `valido` wins.

## Structure
- Shared package `tusca_pkg`:
  - state encoding as 4-bit localparams;
  - requester indices `REQ_MEDIDA`=0, `REQ_CONFIG`=1, `REQ_ERRO`=2.
- Sub-module `rr_picker`: combinational round-robin selector. Inputs `req[2:0]` and `ptr[1:0]`; outputs one-hot `sel[2:0]` and `idx[1:0]`.
- The watchdog counter reuses the existing modulo counter with `TIMEOUT` as the modulus.

## Test plan
- Single message: req0 sends 0x54, 0x32 (`ultimo` on the second byte), `tx_pronto` 10 cycles after each `tx_partida` → `tx_dados` = 0x54 then 0x32, two `aceito[0]` pulses, `grant` back to 0 and `db_estado`=0.
- Contention: `req`=3'b111 from IDLE, each requester sends 1 byte → grant order 0, 1, 2. Then req0 and req2 → order 0, 2. No byte is interleaved between messages.
- Stalled requester: with `TIMEOUT`=20, req1 granted and `valido` never asserted → `timeout_erro` pulses exactly 20 cycles after entry to ESPERA_DADO, then `grant`=0 and req2 is served next.
- Stalled UART: `tx_pronto` never arrives → `timeout_erro` after `TIMEOUT` cycles in AGUARDA_TX; the next message proceeds normally.
- Abort: req0 drops after its first of three bytes → LIBERA, no further `tx_partida`. Non-granted `valido` pulses cause no `aceito`.
- Reset: `reset` low during AGUARDA_TX → all outputs at reset values the same cycle. After release with req0 high, requester 0 is granted first.
